uart_rx_core: RTL and testbench
===============================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate in bit/s.
REQ-003 Derived constant BIT_CNT = CLK_FREQ/BAUD (integer division; 5208 at defaults); HALF_CNT = BIT_CNT/2 (2604).
REQ-004 clk  input  1  system clock; all logic on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rx232  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-007 data_rx  output  8  last correctly received byte; held until the next valid frame.
REQ-008 over_rx  output  1  one-cycle pulse; data_rx is valid and new in the same cycle.
REQ-009 frame_err  output  1  one-cycle pulse; the stop bit sampled low.
REQ-010 rx_busy  output  1  high from start-edge detection until return to IDLE.

Function
REQ-011 rx232 SHALL pass through a 2-flop synchronizer and then a third edge-detect flop before any use.
REQ-012 The FSM SHALL have the states IDLE, START, DATA and STOP; the state register is 2 bits wide.
REQ-013 IDLE: on a synchronized falling edge (previous 1, current 0), go to START, clear the baud counter and set rx_busy.
REQ-014 The baud counter SHALL count 0..BIT_CNT-1 and wrap to 0; in START it compares against HALF_CNT-1 instead.
REQ-015 START at count HALF_CNT-1: if the synchronized line is 0, go to DATA and clear the counter and bit index; if it is 1 (glitch or false start), return to IDLE with no output pulse.
REQ-016 DATA: each time the count reaches BIT_CNT-1 (mid-bit), sample the line into shift[bit_idx]; bit_idx SHALL be a 3-bit counter running 0..7.
REQ-017 After sampling bit_idx=7, go to STOP with the counter cleared.
REQ-018 STOP at count BIT_CNT-1: if the line is 1, load data_rx from the shift register and pulse over_rx on the next cycle; if the line is 0, pulse frame_err on the next cycle and leave data_rx unchanged; in both cases go to IDLE.
REQ-019 over_rx and frame_err SHALL never be high in the same cycle, and each SHALL be high for exactly one clk.
REQ-020 rx_busy SHALL fall in the same cycle that the FSM enters IDLE.
REQ-021 A falling edge in IDLE in the cycle directly after STOP SHALL be accepted (back-to-back frames with no idle gap).
REQ-022 While not in IDLE, line edges SHALL be ignored; only the mid-bit samples matter.
REQ-023 A line held low continuously (break condition) SHALL produce one frame_err, then no new frame until the line has returned high and fallen again.
REQ-024 Latency from the start-bit falling edge on rx232 to over_rx SHALL be 3 synchronizer cycles + HALF_CNT + 9*BIT_CNT + 1 clk, +/-1 clk.

Reset
REQ-025 While rst is high: FSM in IDLE, data_rx=8'h00, over_rx=0, frame_err=0, rx_busy=0, counters and shift register cleared, synchronizer flops set to 1.
REQ-026 Reset asserted in the middle of a frame SHALL abort it with no output pulse; after release, the remainder of that frame SHALL NOT produce a pulse unless a new falling edge is seen.

Verification
REQ-027 Single frame 8'b01001001 (0x49) at 9600 baud, 50 MHz clock -> one over_rx pulse, data_rx=0x49, frame_err never high, rx_busy low afterwards.
REQ-028 Two back-to-back frames, 0x00 then 0xFF, with no idle gap -> two over_rx pulses, data_rx=0x00 then 0xFF.
REQ-029 Low glitch of 1000 clk (shorter than HALF_CNT) on an idle line -> return to IDLE, no pulses, data_rx unchanged.
REQ-030 Frame 0xA5 with the stop bit forced low -> one frame_err pulse, no over_rx, data_rx keeps its previous value.
REQ-031 rst asserted for 5 clk during data bit 4 of frame 0x3C -> all outputs at reset values, no pulse for the aborted frame; the next clean frame 0x5A is received correctly.
REQ-032 Break: rx232 held low for 20*BIT_CNT clk, then high -> exactly one frame_err; a following frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with a 2-flop synchronizer plus an edge-detect
// flop, a 4-state bit-timing FSM and registered one-cycle result pulses.
//
// Handshake: over_rx and frame_err are single-cycle, mutually exclusive
// pulses with no back-pressure. data_rx is valid in the cycle over_rx is high,
// and it holds that value until the next correctly framed byte arrives.
module uart_rx_core #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx232,
    output logic [7:0] data_rx,
    output logic       over_rx,
    output logic       frame_err,
    output logic       rx_busy,
    output logic [1:0] state_dbg
);

    localparam int BIT_CNT  = CLK_FREQ / BAUD;
    localparam int HALF_CNT = BIT_CNT / 2;
    localparam int CNT_W    = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;

    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(BIT_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_CNT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    // sync_q[0], sync_q[1]: metastability chain; sync_q[2]: previous value for edge detect
    logic [2:0]       sync_q, sync_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             over_q, over_d;
    logic             ferr_q, ferr_d;

    logic rx_s;
    logic rx_fall;

    assign rx_s    = sync_q[1];
    assign rx_fall = sync_q[2] & ~sync_q[1];

    // Shift the raw line into the synchronizer / edge-detect chain
    always_comb begin
        sync_d = {sync_q[1:0], rx232};
    end

    // Bit-timing FSM: start qualification at half a bit, then mid-bit sampling
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        over_d    = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // Edges are only looked at here; elsewhere only mid-bit samples count
                if (rx_fall) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end

            START: begin
                if (cnt_q == CNT_HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        // Line back high at mid start bit: glitch, drop it silently
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        data_d = shift_q;
                        over_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers; synchronizer idles high so reset never fakes an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 3'b111;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            over_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            over_q    <= over_d;
            ferr_q    <= ferr_d;
        end
    end

    // Busy tracks the FSM directly so it drops in the cycle IDLE is entered
    assign rx_busy   = (state_q != IDLE);
    assign data_rx   = data_q;
    assign over_rx   = over_q;
    assign frame_err = ferr_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: drives 8N1 frames at a reduced baud divisor and checks
// result pulses, received bytes, held data and start-to-pulse latency.
module tb_uart_rx_core;

    localparam int CLK_FREQ = 3200000;
    localparam int BAUD     = 100000;
    localparam int BIT      = CLK_FREQ / BAUD;
    localparam int HALF     = BIT / 2;
    localparam int LAT_NOM  = 3 + HALF + 9 * BIT + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx232 = 1'b1;
    logic [7:0] data_rx;
    logic       over_rx;
    logic       frame_err;
    logic       rx_busy;
    logic [1:0] state_dbg;

    uart_rx_core #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx232     (rx232),
        .data_rx   (data_rx),
        .over_rx   (over_rx),
        .frame_err (frame_err),
        .rx_busy   (rx_busy),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // ---------------- reference model / scoreboard ----------------
    // Each entry: bit 8 = framing error expected, bits 7:0 = byte sent
    logic [8:0]  exp_q[$];
    int unsigned start_q[$];
    logic [7:0]  hold = 8'h00;

    always @(negedge clk) begin
        if (!rst && (over_rx || frame_err)) begin
            logic [8:0]  e;
            int unsigned s;
            int unsigned lat;
            check("pulse_exclusive", {31'd0, over_rx & frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                check("spurious_pulse", {30'd0, over_rx, frame_err}, 32'd0);
            end else begin
                e   = exp_q.pop_front();
                s   = start_q.pop_front();
                lat = cyc - s;
                check("frame_err_kind", {31'd0, frame_err}, {31'd0, e[8]});
                check("over_rx_kind", {31'd0, over_rx}, {31'd0, ~e[8]});
                check($sformatf("latency_window_lat%0d", lat),
                      {31'd0, (lat >= LAT_NOM - 1) && (lat <= LAT_NOM + 1)}, 32'd1);
                if (!e[8]) begin
                    hold = e[7:0];
                    check("data_rx_new", {24'd0, data_rx}, {24'd0, e[7:0]});
                end else begin
                    check("data_rx_held_on_err", {24'd0, data_rx}, {24'd0, hold});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input int n);
        rx232 = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int gap);
        check("idle_before_frame", {31'd0, rx_busy}, 32'd0);
        exp_q.push_back({~stop_ok, d});
        start_q.push_back(cyc);
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(d[i], BIT);
        drive(stop_ok, BIT);
        if (gap > 0) drive(1'b1, gap);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] abort_byte;
        logic [7:0] rd;
        logic       rok;
        int         rgap;

        // Reset state
        rx232 = 1'b1;
        rst   = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_data_rx", {24'd0, data_rx}, 32'd0);
        check("rst_over_rx", {31'd0, over_rx}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        rst = 1'b0;
        drive(1'b1, 2 * BIT);

        // Single frame
        send_frame(8'h49, 1'b1, 2 * BIT);
        check("single_data", {24'd0, data_rx}, 32'h49);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 2 * BIT);
        check("b2b_data", {24'd0, data_rx}, 32'hFF);

        // Short low glitch: start is taken, then rejected at mid start bit
        drive(1'b0, HALF / 2);
        check("glitch_busy", {31'd0, rx_busy}, 32'd1);
        drive(1'b1, 2 * BIT);
        check("glitch_idle", {31'd0, rx_busy}, 32'd0);
        check("glitch_data", {24'd0, data_rx}, {24'd0, hold});

        // Stop bit forced low
        send_frame(8'hA5, 1'b0, 2 * BIT);
        check("ferr_data_held", {24'd0, data_rx}, 32'hFF);

        // Reset mid-frame during data bit 4; the sender is reset too and idles high
        abort_byte = 8'h3C;
        check("abort_idle_before", {31'd0, rx_busy}, 32'd0);
        drive(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive(abort_byte[i], BIT);
        drive(abort_byte[4], HALF);
        check("abort_busy_mid_frame", {31'd0, rx_busy}, 32'd1);
        rst = 1'b1;
        rx232 = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_rst_data", {24'd0, data_rx}, 32'd0);
        check("abort_rst_busy", {31'd0, rx_busy}, 32'd0);
        check("abort_rst_pulses", {30'd0, over_rx, frame_err}, 32'd0);
        rst  = 1'b0;
        hold = 8'h00;
        drive(1'b1, 12 * BIT);
        check("abort_after_data", {24'd0, data_rx}, 32'd0);
        check("abort_after_idle", {31'd0, rx_busy}, 32'd0);
        send_frame(8'h5A, 1'b1, 2 * BIT);
        check("after_abort_data", {24'd0, data_rx}, 32'h5A);

        // Break: line low for 20 bit times gives exactly one framing error
        check("break_idle_before", {31'd0, rx_busy}, 32'd0);
        exp_q.push_back({1'b1, 8'h00});
        start_q.push_back(cyc);
        drive(1'b0, 20 * BIT);
        check("break_idle_low_line", {31'd0, rx_busy}, 32'd0);
        drive(1'b1, 2 * BIT);
        check("break_data_held", {24'd0, data_rx}, 32'h5A);
        send_frame(8'h81, 1'b1, 2 * BIT);
        check("after_break_data", {24'd0, data_rx}, 32'h81);

        // Randomized frames; a bad stop bit is always followed by idle so the next start edge exists
        for (int k = 0; k < 12; k++) begin
            rd   = 8'($urandom_range(0, 255));
            rok  = ($urandom_range(0, 3) != 0);
            rgap = rok ? int'($urandom_range(0, 2 * BIT)) : BIT + int'($urandom_range(0, BIT));
            send_frame(rd, rok, rgap);
        end
        drive(1'b1, 3 * BIT);

        check("pending_events", exp_q.size(), 32'd0);
        check("final_hold", {24'd0, data_rx}, {24'd0, hold});
        check("final_idle", {31'd0, rx_busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
